dac_sample_scheduler: RTL

Sequences PWM DAC playback. Buffers incoming sample codes in a small FIFO behind a valid/ready interface and primes the buffer before playback starts. Presents one new code to the DAC per PWM window, in step with the DAC's next_sample pulse. Detects and counts underflows and re-primes after each one; supports mute and enable control. Sits between the sample source (tone generator or ROM player) and the dac block.

---
 rtl/dac_pkg.sv | 18 +
 rtl/sample_fifo.sv | 55 +++++
 rtl/dac_sample_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the PWM DAC sample scheduler: state encoding,
// underflow counter width and the FIFO occupancy width helper.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    localparam int UNDERFLOW_CNT_WIDTH = 16;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; clear flushes it in one cycle and wins over push.
module sample_fifo
    import dac_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [occ_width(DEPTH)-1:0]  count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !clear) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Buffers sample codes and hands one to the PWM DAC per window, priming the
// buffer before playback and re-priming after every underflow.
module dac_sample_scheduler
    import dac_pkg::*;
#(
    parameter int                    CYCLES_PER_WINDOW = 1024,
    parameter int                    CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW),
    parameter int                    FIFO_DEPTH        = 8,
    parameter int                    PRIME_LEVEL       = 4,
    parameter logic [CODE_WIDTH-1:0] IDLE_CODE         = '0,
    parameter int                    CNT_WIDTH         = UNDERFLOW_CNT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              mute,
    input  logic [CODE_WIDTH-1:0]             in_code,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              next_sample,
    output logic [CODE_WIDTH-1:0]             code,
    output logic                              playing,
    output logic                              underflow,
    output logic [CNT_WIDTH-1:0]              underflow_count,
    output logic [occ_width(FIFO_DEPTH)-1:0]  fill_level
);

    localparam int FW = occ_width(FIFO_DEPTH);

    state_t                state_q, state_d;
    logic [CODE_WIDTH-1:0] code_q, code_d;
    logic                  playing_q;
    logic                  underflow_q, underflow_d;
    logic [CNT_WIDTH-1:0]  ucnt_q, ucnt_d;

    logic                  fifo_push, fifo_pop, fifo_clear;
    logic                  fifo_full, fifo_empty;
    logic [CODE_WIDTH-1:0] fifo_head;
    logic [FW-1:0]         fifo_count;

    assign in_ready  = (state_q != IDLE) && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    sample_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear),
        .push  (fifo_push),
        .din   (in_code),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        underflow_d = 1'b0;
        ucnt_d      = ucnt_q;
        fifo_pop    = 1'b0;
        fifo_clear  = 1'b0;
        unique case (state_q)
            IDLE: begin
                fifo_clear = 1'b1;
                code_d     = IDLE_CODE;
                if (enable) state_d = PRIME;
            end
            PRIME: begin
                if (!enable) begin
                    state_d    = IDLE;
                    fifo_clear = 1'b1;
                    code_d     = IDLE_CODE;
                end else if (fifo_count >= FW'(PRIME_LEVEL)) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // Disable outranks a coincident window pulse, so no underflow is counted then.
                if (!enable) begin
                    state_d    = IDLE;
                    fifo_clear = 1'b1;
                    code_d     = IDLE_CODE;
                end else if (next_sample) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        code_d   = mute ? IDLE_CODE : fifo_head;
                    end else begin
                        underflow_d = 1'b1;
                        state_d     = PRIME;
                        if (ucnt_q != {CNT_WIDTH{1'b1}}) ucnt_d = ucnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                fifo_clear = 1'b1;
                code_d     = IDLE_CODE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            code_q      <= IDLE_CODE;
            playing_q   <= 1'b0;
            underflow_q <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            playing_q   <= (state_d == PLAY);
            underflow_q <= underflow_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign code            = code_q;
    assign playing         = playing_q;
    assign underflow       = underflow_q;
    assign underflow_count = ucnt_q;
    assign fill_level      = fifo_count;

endmodule
